// File: rtl/regfile_pipe_if.sv
// Bundle between decode/writeback and the register file: read ports, two
// write ports and the issue strobe that marks a destination register busy.
interface regfile_pipe_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NREAD  = 2
);
    logic [NREAD*ADDR_W-1:0] read_reg;
    logic [NREAD*DATA_W-1:0] read_data;
    logic [NREAD-1:0]        read_busy;
    logic                    regwrite0;
    logic [ADDR_W-1:0]       write_reg0;
    logic [DATA_W-1:0]       write_data0;
    logic                    regwrite1;
    logic [ADDR_W-1:0]       write_reg1;
    logic [DATA_W-1:0]       write_data1;
    logic                    issue_valid;
    logic [ADDR_W-1:0]       issue_reg;

    modport master (
        output read_reg, regwrite0, write_reg0, write_data0,
               regwrite1, write_reg1, write_data1, issue_valid, issue_reg,
        input  read_data, read_busy
    );

    modport slave (
        input  read_reg, regwrite0, write_reg0, write_data0,
               regwrite1, write_reg1, write_data1, issue_valid, issue_reg,
        output read_data, read_busy
    );
endinterface

// File: rtl/regfile_pipe.sv
// Multi-read, dual-write register file with hardwired zero register,
// same-cycle write bypass and a per-register busy scoreboard for hazard stalls.
module regfile_pipe #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NREAD    = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    regfile_pipe_if.slave  bus
);
    localparam int DEPTH   = 1 << ADDR_W;
    localparam bit ZERO_EN = (ZERO_REG != 32'sd0);
    localparam bit BYP_EN  = (BYPASS != 32'sd0);

    logic [DATA_W-1:0] regs_r [DEPTH];
    logic [DEPTH-1:0]  busy_r;
    logic [DEPTH-1:0]  busy_nxt_s;
    logic              wr0_ok_s;
    logic              wr1_ok_s;
    logic              issue_ok_s;

    function automatic logic is_zero(input logic [ADDR_W-1:0] a);
        return ZERO_EN && (a == {ADDR_W{1'b0}});
    endfunction

    // A write held during the reset edge is discarded, so it must not bypass either.
    assign wr0_ok_s   = rst_n && bus.regwrite0 && !is_zero(bus.write_reg0);
    assign wr1_ok_s   = rst_n && bus.regwrite1 && !is_zero(bus.write_reg1);
    assign issue_ok_s = bus.issue_valid && !is_zero(bus.issue_reg);

    // Next busy vector: issue sets (beats a same-cycle write), a write clears.
    always_comb begin
        busy_nxt_s = busy_r;
        for (int r = 0; r < DEPTH; r++) begin
            busy_nxt_s[r] = (issue_ok_s && (bus.issue_reg == ADDR_W'(r))) ? 1'b1 :
                            ((wr0_ok_s && (bus.write_reg0 == ADDR_W'(r))) ||
                             (wr1_ok_s && (bus.write_reg1 == ADDR_W'(r)))) ? 1'b0 :
                            busy_r[r];
        end
    end

    // Storage and scoreboard update; port 1 is assigned last so it wins a collision.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            regs_r <= '{default: '0};
            busy_r <= '0;
        end else begin
            if (wr0_ok_s) begin
                regs_r[bus.write_reg0] <= bus.write_data0;
            end
            if (wr1_ok_s) begin
                regs_r[bus.write_reg1] <= bus.write_data1;
            end
            busy_r <= busy_nxt_s;
        end
    end

    for (genvar i = 0; i < NREAD; i++) begin : g_read
        logic [ADDR_W-1:0] addr_s;
        logic [DATA_W-1:0] data_s;
        logic              busy_s;

        assign addr_s = bus.read_reg[i*ADDR_W +: ADDR_W];

        // Read mux: zero register, then bypass (port 1 first), then storage.
        always_comb begin
            data_s = regs_r[addr_s];
            busy_s = busy_r[addr_s];
            if (is_zero(addr_s)) begin
                data_s = '0;
                busy_s = 1'b0;
            end else if (BYP_EN && wr1_ok_s && (bus.write_reg1 == addr_s)) begin
                data_s = bus.write_data1;
                busy_s = 1'b0;
            end else if (BYP_EN && wr0_ok_s && (bus.write_reg0 == addr_s)) begin
                data_s = bus.write_data0;
                busy_s = 1'b0;
            end else begin
                data_s = regs_r[addr_s];
                busy_s = busy_r[addr_s];
            end
        end

        assign bus.read_data[i*DATA_W +: DATA_W] = data_s;
        assign bus.read_busy[i]                  = busy_s;
    end
endmodule

// File: tb/tb_regfile_pipe.sv
// Self-checking bench for regfile_pipe (default parameters: zero register and bypass on).
module tb_regfile_pipe;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    regfile_pipe_if #(.DATA_W(32), .ADDR_W(5), .NREAD(2)) bus ();

    regfile_pipe dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference state: architectural register contents and outstanding producers.
    logic [31:0] m_regs [32];
    bit          m_busy [32];

    function automatic logic [31:0] ref_data(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (rst_n && bus.regwrite1 && bus.write_reg1 == a) return bus.write_data1;
        if (rst_n && bus.regwrite0 && bus.write_reg0 == a) return bus.write_data0;
        return m_regs[a];
    endfunction

    function automatic logic ref_busy(input logic [4:0] a);
        if (a == 5'd0) return 1'b0;
        if (rst_n && bus.regwrite1 && bus.write_reg1 == a) return 1'b0;
        if (rst_n && bus.regwrite0 && bus.write_reg0 == a) return 1'b0;
        return m_busy[a];
    endfunction

    task automatic step();
        @(posedge clk);
        if (!rst_n) begin
            for (int r = 0; r < 32; r++) begin
                m_regs[r] = 32'd0;
                m_busy[r] = 1'b0;
            end
        end else begin
            if (bus.regwrite0 && bus.write_reg0 != 5'd0) begin
                m_regs[bus.write_reg0] = bus.write_data0;
                m_busy[bus.write_reg0] = 1'b0;
            end
            if (bus.regwrite1 && bus.write_reg1 != 5'd0) begin
                m_regs[bus.write_reg1] = bus.write_data1;
                m_busy[bus.write_reg1] = 1'b0;
            end
            if (bus.issue_valid && bus.issue_reg != 5'd0) m_busy[bus.issue_reg] = 1'b1;
        end
        #1;
    endtask

    task automatic idle();
        bus.regwrite0 = 1'b0; bus.write_reg0 = 5'd0; bus.write_data0 = 32'd0;
        bus.regwrite1 = 1'b0; bus.write_reg1 = 5'd0; bus.write_data1 = 32'd0;
        bus.issue_valid = 1'b0; bus.issue_reg = 5'd0;
    endtask

    task automatic set_rd(input logic [4:0] p0, input logic [4:0] p1);
        bus.read_reg = {p1, p0};
    endtask

    task automatic test_reset();
        idle(); set_rd(5'd5, 5'd0);
        rst_n = 1'b0; step(); rst_n = 1'b1;
        bus.regwrite0 = 1'b1; bus.write_reg0 = 5'd5; bus.write_data0 = 32'h1234;
        step(); idle(); #1;
        checks++;
        if (bus.read_data[31:0] !== 32'h1234) begin
            errors++; $display("FAIL preload: got %h expected %h", bus.read_data[31:0], 32'h1234);
        end
        bus.issue_valid = 1'b1; bus.issue_reg = 5'd5;
        rst_n = 1'b0; step(); rst_n = 1'b1; idle(); #1;
        checks++;
        if (bus.read_data[31:0] !== 32'd0 || bus.read_busy !== 2'b00) begin
            errors++; $display("FAIL reset: got data %h busy %b expected 0 / 00", bus.read_data[31:0], bus.read_busy);
        end
    endtask

    task automatic test_write_readback();
        idle(); set_rd(5'd12, 5'd3);
        bus.regwrite0 = 1'b1; bus.write_reg0 = 5'd12; bus.write_data0 = 32'd7; #1;
        checks++;
        if (bus.read_data[31:0] !== 32'd7 || bus.read_data[63:32] !== 32'd0) begin
            errors++; $display("FAIL bypass_w0: got %h/%h expected 7/0", bus.read_data[31:0], bus.read_data[63:32]);
        end
        step(); idle(); #1;
        checks++;
        if (bus.read_data[31:0] !== 32'd7) begin
            errors++; $display("FAIL readback: got %h expected 7", bus.read_data[31:0]);
        end
    endtask

    task automatic test_collision();
        idle(); set_rd(5'd12, 5'd9);
        bus.regwrite0 = 1'b1; bus.write_reg0 = 5'd9; bus.write_data0 = 32'hAAAA;
        bus.regwrite1 = 1'b1; bus.write_reg1 = 5'd9; bus.write_data1 = 32'h5555; #1;
        checks++;
        if (bus.read_data[63:32] !== 32'h5555) begin
            errors++; $display("FAIL collision_bypass: got %h expected 5555", bus.read_data[63:32]);
        end
        step(); idle(); #1;
        checks++;
        if (bus.read_data[63:32] !== 32'h5555 || bus.read_data[31:0] !== 32'd7) begin
            errors++; $display("FAIL collision_store: got %h/%h expected 5555/7", bus.read_data[63:32], bus.read_data[31:0]);
        end
    endtask

    task automatic test_zero();
        idle(); set_rd(5'd0, 5'd0);
        bus.regwrite0 = 1'b1; bus.write_reg0 = 5'd0; bus.write_data0 = 32'hFFFF_FFFF;
        bus.regwrite1 = 1'b1; bus.write_reg1 = 5'd0; bus.write_data1 = 32'hFFFF_FFFF;
        bus.issue_valid = 1'b1; bus.issue_reg = 5'd0; #1;
        checks++;
        if (bus.read_data !== 64'd0 || bus.read_busy !== 2'b00) begin
            errors++; $display("FAIL zero_same: got %h busy %b expected 0 / 00", bus.read_data, bus.read_busy);
        end
        step(); idle(); #1;
        checks++;
        if (bus.read_data !== 64'd0 || bus.read_busy !== 2'b00) begin
            errors++; $display("FAIL zero_next: got %h busy %b expected 0 / 00", bus.read_data, bus.read_busy);
        end
    endtask

    task automatic test_scoreboard();
        idle(); set_rd(5'd17, 5'd16);
        bus.issue_valid = 1'b1; bus.issue_reg = 5'd17;
        step(); idle();
        for (int c = 1; c <= 2; c++) begin
            #1;
            checks++;
            if (bus.read_busy !== 2'b01) begin
                errors++; $display("FAIL busy_cycle%0d: got %b expected 01", c, bus.read_busy);
            end
            step();
        end
        bus.regwrite0 = 1'b1; bus.write_reg0 = 5'd17; bus.write_data0 = 32'd4; #1;
        checks++;
        if (bus.read_busy !== 2'b00 || bus.read_data[31:0] !== 32'd4) begin
            errors++; $display("FAIL writeback_same: got busy %b data %h expected 00 / 4", bus.read_busy, bus.read_data[31:0]);
        end
        step(); idle(); #1;
        checks++;
        if (bus.read_busy !== 2'b00 || bus.read_data[31:0] !== 32'd4) begin
            errors++; $display("FAIL writeback_next: got busy %b data %h expected 00 / 4", bus.read_busy, bus.read_data[31:0]);
        end
    endtask

    task automatic test_issue_write_overlap();
        idle(); set_rd(5'd20, 5'd20);
        bus.issue_valid = 1'b1; bus.issue_reg = 5'd20;
        step();
        bus.regwrite1 = 1'b1; bus.write_reg1 = 5'd20; bus.write_data1 = 32'd1; #1;
        checks++;
        if (bus.read_data[31:0] !== 32'd1 || bus.read_busy !== 2'b00) begin
            errors++; $display("FAIL overlap_same: got data %h busy %b expected 1 / 00", bus.read_data[31:0], bus.read_busy);
        end
        step(); idle(); #1;
        checks++;
        if (bus.read_data[31:0] !== 32'd1 || bus.read_busy !== 2'b11) begin
            errors++; $display("FAIL overlap_next: got data %h busy %b expected 1 / 11", bus.read_data[31:0], bus.read_busy);
        end
    endtask

    task automatic test_random();
        logic [31:0] exp_d;
        logic        exp_b;
        for (int n = 0; n < 400; n++) begin
            rst_n = ($urandom_range(0, 59) != 0);
            bus.regwrite0   = $urandom_range(0, 1);
            bus.write_reg0  = 5'($urandom_range(0, 7));
            bus.write_data0 = $urandom;
            bus.regwrite1   = $urandom_range(0, 2) == 0;
            bus.write_reg1  = 5'($urandom_range(0, 7));
            bus.write_data1 = $urandom;
            bus.issue_valid = $urandom_range(0, 1);
            bus.issue_reg   = 5'($urandom_range(0, 7));
            set_rd(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            #1;
            if (rst_n) begin
                for (int p = 0; p < 2; p++) begin
                    exp_d = ref_data(bus.read_reg[p*5 +: 5]);
                    exp_b = ref_busy(bus.read_reg[p*5 +: 5]);
                    checks++;
                    if (bus.read_data[p*32 +: 32] !== exp_d || bus.read_busy[p] !== exp_b) begin
                        errors++;
                        $display("FAIL random[%0d] port%0d r%0d: got %h/%b expected %h/%b", n, p,
                                 bus.read_reg[p*5 +: 5], bus.read_data[p*32 +: 32], bus.read_busy[p], exp_d, exp_b);
                    end
                end
            end
            step();
        end
        rst_n = 1'b1;
    endtask

    initial begin
        idle(); set_rd(5'd0, 5'd0);
        test_reset();
        test_write_readback();
        test_collision();
        test_zero();
        test_scoreboard();
        test_issue_write_overlap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
